// File: rtl/traffic_phase_sequencer_if.sv
// Bundle of the control inputs and display/lamp outputs of the traffic
// phase sequencer. Clock and reset stay plain ports on the module.
//   master : drives run/flash, observes lights, seconds, phase and tick
//   slave  : the sequencer itself
interface traffic_phase_sequencer_if;
    logic       run;             // 1 = prescaler advances
    logic       flash;           // night mode, both directions blink yellow
    logic [2:0] row_lights;      // {red,yellow,green}
    logic [2:0] column_lights;   // {red,yellow,green}
    logic [6:0] row_seconds;     // seconds left on the row light
    logic [6:0] column_seconds;  // seconds left on the column light
    logic [1:0] phase;           // current phase number
    logic       tick;            // one-cycle pulse per 1 s boundary

    modport master (
        output run,
        output flash,
        input  row_lights,
        input  column_lights,
        input  row_seconds,
        input  column_seconds,
        input  phase,
        input  tick
    );

    modport slave (
        input  run,
        input  flash,
        output row_lights,
        output column_lights,
        output row_seconds,
        output column_seconds,
        output phase,
        output tick
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Timing stage of the crossroads light controller: divides clock down to a
// 1 s tick and steps the four-phase row/column cycle
// (G_ROW -> Y_ROW -> G_COL -> Y_COL), producing one-hot lamp codes and the
// seconds left on each direction's light. Flash mode blinks both yellows.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - slave modport: run, flash in; lights, seconds, phase, tick out
module traffic_phase_sequencer #(
    parameter int CLK_DIV     = 50_000_000,
    parameter int GREEN_TIME  = 28,
    parameter int YELLOW_TIME = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    traffic_phase_sequencer_if.slave       bus
);
    localparam int               PRE_W      = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(CLK_DIV - 1);
    localparam logic [6:0]       GREEN_SEC  = 7'(GREEN_TIME);
    localparam logic [6:0]       YELLOW_SEC = 7'(YELLOW_TIME);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [1:0] {
        G_ROW = 2'd0,
        Y_ROW = 2'd1,
        G_COL = 2'd2,
        Y_COL = 2'd3
    } phase_t;

    logic [PRE_W-1:0] prescaler_reg, prescaler_next;
    phase_t           phase_reg, phase_next;
    logic [6:0]       sec_left_reg, sec_left_next;
    logic             blink_reg, blink_next;
    logic             flash_mode_reg, flash_mode_next;
    logic [2:0]       row_lights_reg, row_lights_next;
    logic [2:0]       column_lights_reg, column_lights_next;
    logic [6:0]       row_seconds_reg, row_seconds_next;
    logic [6:0]       column_seconds_reg, column_seconds_next;
    logic             tick_w;

    // Odd phases are the yellow phases.
    function automatic logic [6:0] duration(input phase_t p);
        return p[0] ? YELLOW_SEC : GREEN_SEC;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler_reg      <= '0;
            phase_reg          <= G_ROW;
            sec_left_reg       <= GREEN_SEC;
            blink_reg          <= 1'b0;
            flash_mode_reg     <= 1'b0;
            row_lights_reg     <= LAMP_GREEN;
            column_lights_reg  <= LAMP_RED;
            row_seconds_reg    <= GREEN_SEC;
            column_seconds_reg <= GREEN_SEC + YELLOW_SEC;
        end else begin
            prescaler_reg      <= prescaler_next;
            phase_reg          <= phase_next;
            sec_left_reg       <= sec_left_next;
            blink_reg          <= blink_next;
            flash_mode_reg     <= flash_mode_next;
            row_lights_reg     <= row_lights_next;
            column_lights_reg  <= column_lights_next;
            row_seconds_reg    <= row_seconds_next;
            column_seconds_reg <= column_seconds_next;
        end
    end

    always_comb begin
        tick_w              = bus.run && (prescaler_reg == PRE_MAX);
        prescaler_next      = prescaler_reg;
        phase_next          = phase_reg;
        sec_left_next       = sec_left_reg;
        blink_next          = blink_reg;
        flash_mode_next     = flash_mode_reg;
        row_lights_next     = LAMP_RED;
        column_lights_next  = LAMP_RED;
        row_seconds_next    = '0;
        column_seconds_next = '0;

        if (bus.run) begin
            prescaler_next = tick_w ? '0 : prescaler_reg + PRE_W'(1);
        end

        if (bus.flash) begin
            // Phase and sec_left are frozen; the prescaler keeps pacing the blink.
            flash_mode_next = 1'b1;
            if (!flash_mode_reg) begin
                blink_next = 1'b1;
            end else if (tick_w) begin
                blink_next = ~blink_reg;
            end
        end else if (flash_mode_reg) begin
            // Leaving night mode restarts a clean cycle with a full first second.
            flash_mode_next = 1'b0;
            blink_next      = 1'b0;
            phase_next      = G_ROW;
            sec_left_next   = GREEN_SEC;
            prescaler_next  = '0;
        end else if (tick_w) begin
            if (sec_left_reg == 7'd1) begin
                phase_next    = phase_t'(phase_reg + 2'd1);
                sec_left_next = duration(phase_t'(phase_reg + 2'd1));
            end else begin
                sec_left_next = sec_left_reg - 7'd1;
            end
        end

        // Output decode from the next state so every output is a register.
        if (flash_mode_next) begin
            row_lights_next    = blink_next ? LAMP_YELLOW : LAMP_DARK;
            column_lights_next = blink_next ? LAMP_YELLOW : LAMP_DARK;
        end else begin
            row_seconds_next    = sec_left_next;
            column_seconds_next = sec_left_next;
            case (phase_next)
                G_ROW: begin
                    row_lights_next     = LAMP_GREEN;
                    // Red side waits through the following yellow as well.
                    column_seconds_next = sec_left_next + YELLOW_SEC;
                end
                Y_ROW: row_lights_next = LAMP_YELLOW;
                G_COL: begin
                    column_lights_next = LAMP_GREEN;
                    row_seconds_next   = sec_left_next + YELLOW_SEC;
                end
                default: column_lights_next = LAMP_YELLOW;
            endcase
        end
    end

    assign bus.tick           = tick_w;
    assign bus.phase          = phase_reg;
    assign bus.row_lights     = row_lights_reg;
    assign bus.column_lights  = column_lights_reg;
    assign bus.row_seconds    = row_seconds_reg;
    assign bus.column_seconds = column_seconds_reg;
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer with CLK_DIV=4,
// GREEN_TIME=28, YELLOW_TIME=4. Expected output snapshots are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT updates.
module tb_traffic_phase_sequencer;
    localparam int CLK_DIV     = 4;
    localparam int GREEN       = 28;
    localparam int YELLOW      = 4;
    localparam int CYCLE_TICKS = 2 * (GREEN + YELLOW);

    logic clock = 1'b0;
    logic reset = 1'b1;

    traffic_phase_sequencer_if bus ();

    traffic_phase_sequencer #(
        .CLK_DIV     (CLK_DIV),
        .GREEN_TIME  (GREEN),
        .YELLOW_TIME (YELLOW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [21:0] value;   // {phase,row_lights,column_lights,row_sec,col_sec}
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t item;
    int n_checks   = 0;
    int n_fail     = 0;
    int ticks_done = 0;
    int steps;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_push(input string name, input logic [21:0] value);
        sb_item_t it;
        it.name  = name;
        it.value = value;
        sb_q.push_back(it);
    endtask

    function automatic logic [21:0] observed();
        return {bus.phase, bus.row_lights, bus.column_lights,
                bus.row_seconds, bus.column_seconds};
    endfunction

    // Snapshot for a normal-mode phase with sec seconds left on the active light.
    function automatic logic [21:0] normal_snap(input int ph, input int sec);
        logic [2:0] r;
        logic [2:0] c;
        int rs;
        int cs;
        case (ph)
            0:       begin r = 3'b001; c = 3'b100; end
            1:       begin r = 3'b010; c = 3'b100; end
            2:       begin r = 3'b100; c = 3'b001; end
            default: begin r = 3'b100; c = 3'b010; end
        endcase
        rs = (ph == 2) ? sec + YELLOW : sec;
        cs = (ph == 0) ? sec + YELLOW : sec;
        return {2'(ph), r, c, 7'(rs), 7'(cs)};
    endfunction

    // Expected state after t ticks since the cycle started at phase 0.
    function automatic logic [21:0] snap_after(input int t);
        int pos;
        pos = t % CYCLE_TICKS;
        if (pos < GREEN)                   return normal_snap(0, GREEN - pos);
        else if (pos < GREEN + YELLOW)     return normal_snap(1, YELLOW - (pos - GREEN));
        else if (pos < 2 * GREEN + YELLOW) return normal_snap(2, GREEN - (pos - GREEN - YELLOW));
        else                               return normal_snap(3, YELLOW - (pos - 2 * GREEN - YELLOW));
    endfunction

    function automatic logic [21:0] flash_snap(input int ph, input bit lit);
        logic [2:0] l;
        l = lit ? 3'b010 : 3'b000;
        return {2'(ph), l, l, 14'd0};
    endfunction

    // Advance until tick is high at the sample point, bounded.
    task automatic wait_tick(input string name, output int n);
        n = 0;
        while (bus.tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (bus.tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: tick=%b after %0d cycles, required 1", name, bus.tick, n);
        end
    endtask

    task automatic test_reset();
        bus.run   = 1'b1;
        bus.flash = 1'b0;
        reset     = 1'b1;
        step();
        step();
        expect_push("reset_state", snap_after(0));
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        n_checks++;
        if (bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tick: got %b required 0", bus.tick);
        end
        $display("reset: outputs %h", observed());
        reset      = 1'b0;
        ticks_done = 0;
    endtask

    // Runs n ticks, checking spacing, post-tick state and lamp legality.
    task automatic test_cycle(input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick("tick_wait", steps);
            n_checks++;
            if (steps + 1 != CLK_DIV) begin
                n_fail++;
                $display("FAIL tick_spacing: got %0d cycles required %0d", steps + 1, CLK_DIV);
            end
            expect_push(((ticks_done + 1) % CYCLE_TICKS == 0) ? "wrap_to_phase0" : "tick_state",
                        snap_after(ticks_done + 1));
            step();
            ticks_done++;
            item = sb_q.pop_front();
            n_checks++;
            if (observed() !== item.value) begin
                n_fail++;
                $display("FAIL %s: tick %0d got %h required %h", item.name, ticks_done, observed(), item.value);
            end
            n_checks++;
            if (!$onehot(bus.row_lights) || !$onehot(bus.column_lights)) begin
                n_fail++;
                $display("FAIL onehot: row %b column %b required one bit each", bus.row_lights, bus.column_lights);
            end
            $display("tick %0d: phase %0d row %b/%0d column %b/%0d", ticks_done, bus.phase,
                     bus.row_lights, bus.row_seconds, bus.column_lights, bus.column_seconds);
        end
    endtask

    task automatic test_pause();
        int gap;
        test_cycle(1);
        step();
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_push("pause_hold", snap_after(ticks_done));
            item = sb_q.pop_front();
            n_checks++;
            if (observed() !== item.value || bus.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: got %h tick %b required %h tick 0", item.name, observed(), bus.tick, item.value);
            end
        end
        bus.run = 1'b1;
        wait_tick("pause_wait", steps);
        gap = 2 + 10 + steps;
        n_checks++;
        if (gap != CLK_DIV + 10) begin
            n_fail++;
            $display("FAIL pause_gap: got %0d cycles required %0d", gap, CLK_DIV + 10);
        end
        expect_push("pause_resume", snap_after(ticks_done + 1));
        step();
        ticks_done++;
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        $display("pause: tick gap %0d cycles, state %h", gap, observed());
    endtask

    task automatic test_flash();
        while (ticks_done % CYCLE_TICKS != 36) test_cycle(1);   // phase 2, sec 24
        bus.flash = 1'b1;
        expect_push("flash_enter", flash_snap(2, 1'b1));
        step();
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        wait_tick("flash_wait", steps);
        expect_push("flash_dark", flash_snap(2, 1'b0));
        step();
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        for (int k = 0; k < 4; k++) begin
            wait_tick("blink_wait", steps);
            n_checks++;
            if (steps + 1 != CLK_DIV) begin
                n_fail++;
                $display("FAIL blink_spacing: got %0d cycles required %0d", steps + 1, CLK_DIV);
            end
            expect_push("flash_toggle", flash_snap(2, (k % 2) == 0));
            step();
            item = sb_q.pop_front();
            n_checks++;
            if (observed() !== item.value) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
            end
            $display("flash toggle %0d: lights %b/%b", k, bus.row_lights, bus.column_lights);
        end
        bus.flash = 1'b0;
        expect_push("flash_release", snap_after(0));
        step();
        ticks_done = 0;
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        $display("flash release: state %h", observed());
        test_cycle(1);
    endtask

    task automatic test_reset_flash();
        while (ticks_done % CYCLE_TICKS != 61) test_cycle(1);   // phase 3, sec 3
        reset     = 1'b1;
        bus.flash = 1'b1;
        bus.run   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_push("reset_over_flash", snap_after(0));
            step();
            item = sb_q.pop_front();
            n_checks++;
            if (observed() !== item.value || bus.tick !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: got %h tick %b required %h tick 0", item.name, observed(), bus.tick, item.value);
            end
        end
        reset = 1'b0;
        expect_push("flash_after_reset", flash_snap(0, 1'b1));
        step();
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        bus.flash = 1'b0;
        expect_push("normal_after_flash", snap_after(0));
        step();
        ticks_done = 0;
        item = sb_q.pop_front();
        n_checks++;
        if (observed() !== item.value) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", item.name, observed(), item.value);
        end
        $display("reset over flash: state %h", observed());
        test_cycle(2);
    endtask

    initial begin
        bus.run   = 1'b0;
        bus.flash = 1'b0;
        test_reset();
        test_cycle(CYCLE_TICKS);
        test_pause();
        test_flash();
        test_reset_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Upstream timing stage of the crossroads traffic-light controller. It divides the system clock down to a 1 s tick and steps a four-phase row/column light cycle. Each cycle it outputs the one-hot light codes for both directions and the seconds remaining on each direction's current light. The light codes drive the lamps directly. The two 7-bit second counts feed the binary-to-BCD and seven-segment display stage.

## Interface
- CLK_DIV, 50_000_000: clock cycles per 1 s tick; legal range ≥2.
- GREEN_TIME, 28: green duration in seconds; legal range 1..95.
- YELLOW_TIME, 4: yellow duration in seconds; legal range 1..4.
- Constraint: GREEN_TIME+YELLOW_TIME ≤ 99, so every count fits two display digits.
- clock  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high; takes effect on the rising edge of clock.
- run  input  1  1 = prescaler advances; 0 = sequencer frozen and outputs held.
- flash  input  1  night mode: both directions blink yellow.
- row_lights  output  3  row lamps, encoded {red,yellow,green}.
- column_lights  output  3  column lamps, same encoding as row_lights.
- row_seconds  output  7  seconds left on the current row light.
- column_seconds  output  7  seconds left on the current column light.
- phase  output  2  current phase number, for debug/observation.
- tick  output  1  single-cycle pulse marking each 1 s boundary.

## Operation
- Light encoding: red=3'b100, yellow=3'b010, green=3'b001, dark=3'b000. In normal mode exactly one bit per direction is set.
- Prescaler: counts 0..CLK_DIV-1, but only while run=1.
  - tick is asserted while prescaler==CLK_DIV-1 and run=1.
  - On that cycle the prescaler wraps to 0.
- Phase sequence; the normal cycle is always 0→1→2→3→0:
  - Phase 0 (G_ROW): row green, column red, lasts GREEN_TIME.
  - Phase 1 (Y_ROW): row yellow, column red, lasts YELLOW_TIME.
  - Phase 2 (G_COL): row red, column green, lasts GREEN_TIME.
  - Phase 3 (Y_COL): row red, column yellow, lasts YELLOW_TIME.
- sec_left (7 bits) is loaded with the duration of the current phase and counts down. On a tick:
  - if sec_left==1, advance to the next phase and load that phase's duration;
  - otherwise decrement sec_left.
  - sec_left never reaches 0 in normal mode.
- Displayed seconds:
  - For the direction showing green or yellow: sec_left.
  - For the direction showing red:
    - sec_left+YELLOW_TIME in a green phase (0 or 2);
    - sec_left in a yellow phase (1 or 3).
  - Example with defaults, phase 0, sec_left=28: row_seconds=28, column_seconds=32.
- Flash mode, entered whenever flash=1 (checked every cycle, independent of run):
  - The phase counter is held.
  - A blink bit is set to 1 on entry and toggles on each tick.
  - Both light outputs show blink ? 3'b010 : 3'b000.
  - Both second counts output 0.
- Leaving flash (flash 1→0): restart at phase 0 with sec_left=GREEN_TIME and prescaler=0.
- run=0 freezes the prescaler, sec_left, phase and blink. All outputs hold, and tick stays 0.
- Reset: prescaler=0, phase=0, sec_left=GREEN_TIME, blink=0.
  - Reset has priority over flash and run.
  - Register values after reset: row_lights=3'b001, column_lights=3'b100, row_seconds=GREEN_TIME, column_seconds=GREEN_TIME+YELLOW_TIME, phase=0, tick=0.

## Timing
- All outputs are registered.
- A tick in cycle N is visible on phase, lights and seconds at cycle N+1. tick itself is high during cycle N, combinational from the prescaler register.
- Tick spacing is exactly CLK_DIV cycles while run=1. A gap in run stretches the spacing by the number of cycles run was low.
- flash rising in cycle N: lights show 3'b010 from cycle N+1.
- flash falling in cycle N: normal phase-0 outputs from cycle N+1, and the first tick comes CLK_DIV cycles after that.
- Reset mid-phase: restarts the cycle from the beginning, with no partial tick carried over.
- Full normal cycle: 2·(GREEN_TIME+YELLOW_TIME) ticks, which is 64 with defaults.

## Test plan
Benches use CLK_DIV=4, GREEN_TIME=28, YELLOW_TIME=4.
- Reset then run=1: first tick at cycle 4 after reset release, then row_seconds=27 and column_seconds=31. After 28 ticks: phase=1, row_lights=010, row_seconds=4, column_seconds=4.
- Full cycle: 64 ticks (256 cycles) return to phase 0 with seconds 28/32. Check the phase order 0,1,2,3 and that exactly one light bit per direction is set throughout.
- Pause: drop run for 10 cycles mid-phase. The next tick is delayed by exactly 10 cycles, and outputs are unchanged during the pause.
- Flash entered during phase 2:
  - lights 010/010 next cycle; seconds 0/0;
  - lights go 000 after the next tick and toggle every 4 cycles.
  - On release: phase 0, 001/100, 28/32.
- Reset asserted together with flash=1 and run=1 in phase 3: outputs return to the reset values; flash takes effect again the cycle after reset drops.
- Boundary: at sec_left==1 in phase 3, a tick wraps the sequencer to phase 0 (not phase 4).
